// File: rtl/ppt_pulse_gen.sv
// PPT thruster pulse generator: prescaled tick, shadowed period/width/count.
// Define PPT_CHARGE_EN to add the registered charge_out output.
module ppt_pulse_gen (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  clk_div,
    input  logic [14:0] period,
    input  logic [14:0] width,
    input  logic [7:0]  count,
    input  logic        run_ppt,
`ifdef PPT_CHARGE_EN
    output logic        charge_out,
`endif
    output logic        pulse_out,
    output logic [7:0]  count_done,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] pre, pre_n;
    logic [14:0] ph, ph_n;
    logic [14:0] sh_period, sh_period_n;
    logic [14:0] sh_width, sh_width_n;
    logic [7:0]  sh_count, sh_count_n;
    logic [7:0]  cnt_n;
    logic        pulse_n;
    logic        done_n;
    logic [31:0] mask;
    logic        tick;

    assign mask = 32'hFFFF_FFFF >> (5'd31 - clk_div);
    assign tick = (pre & mask) == mask;

    always_comb begin
        state_n     = state;
        pre_n       = pre;
        ph_n        = ph;
        sh_period_n = sh_period;
        sh_width_n  = sh_width;
        sh_count_n  = sh_count;
        cnt_n       = count_done;
        unique case (state)
            IDLE: begin
                if (run_ppt) begin
                    // period=0 behaves as period=1
                    sh_period_n = (period == 15'd0) ? 15'd1 : period;
                    sh_width_n  = width;
                    sh_count_n  = count;
                    pre_n       = 32'd0;
                    ph_n        = 15'd0;
                    cnt_n       = 8'd0;
                    state_n     = (count == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!run_ppt) begin
                    state_n = IDLE;
                end else begin
                    pre_n = pre + 32'd1;
                    if (tick) begin
                        if (ph == sh_period - 15'd1) begin
                            ph_n  = 15'd0;
                            cnt_n = count_done + 8'd1;
                            if (cnt_n == sh_count)
                                state_n = DONE;
                        end else begin
                            ph_n = ph + 15'd1;
                        end
                    end
                end
            end
            DONE: begin
                if (!run_ppt)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        pulse_n = (state_n == RUN) && (ph_n < sh_width_n);
        done_n  = (state_n == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            pre        <= 32'd0;
            ph         <= 15'd0;
            sh_period  <= 15'd0;
            sh_width   <= 15'd0;
            sh_count   <= 8'd0;
            count_done <= 8'd0;
            pulse_out  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            pre        <= pre_n;
            ph         <= ph_n;
            sh_period  <= sh_period_n;
            sh_width   <= sh_width_n;
            sh_count   <= sh_count_n;
            count_done <= cnt_n;
            pulse_out  <= pulse_n;
            done       <= done_n;
        end
    end

`ifdef PPT_CHARGE_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            charge_out <= 1'b0;
        else
            charge_out <= (state_n == RUN) && !pulse_n;
    end
`endif

endmodule

// File: tb/tb_ppt_pulse_gen.sv
// Directed bench for ppt_pulse_gen; cycle k = value after the k-th edge of a run.
module tb_ppt_pulse_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  clk_div;
    logic [14:0] period;
    logic [14:0] width;
    logic [7:0]  count;
    logic        run_ppt;
    logic        pulse_out;
    logic [7:0]  count_done;
    logic        done;
`ifdef PPT_CHARGE_EN
    logic        charge_out;
`endif

    int errors = 0;
    int checks = 0;

    ppt_pulse_gen dut (
        .clk        (clk),
        .rstn       (rstn),
        .clk_div    (clk_div),
        .period     (period),
        .width      (width),
        .count      (count),
        .run_ppt    (run_ppt),
`ifdef PPT_CHARGE_EN
        .charge_out (charge_out),
`endif
        .pulse_out  (pulse_out),
        .count_done (count_done),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_p28(input int k);
        return (k == 1 || k == 2 || k == 9 || k == 10 || k == 17 || k == 18);
    endfunction

    initial begin
        rstn    = 1'b0;
        clk_div = 5'd0;
        period  = 15'd4;
        width   = 15'd1;
        count   = 8'd3;
        run_ppt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pulse", {31'd0, pulse_out}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cnt", {24'd0, count_done}, 32'd0);
        rstn = 1'b1;
        cyc();

        // basic run: 3 pulses of 2 cycles, done at cycle 25
        run_ppt = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            cyc();
            chk($sformatf("p28_pulse_k%0d", k), {31'd0, pulse_out},
                {31'd0, exp_p28(k)});
`ifdef PPT_CHARGE_EN
            chk($sformatf("p28_chg_k%0d", k), {31'd0, charge_out},
                {31'd0, (k <= 24) ? !exp_p28(k) : 1'b0});
`endif
            if (k == 9)
                chk("p28_cnt9", {24'd0, count_done}, 32'd1);
            if (k == 24)
                chk("p28_done24", {31'd0, done}, 32'd0);
            if (k == 25) begin
                chk("p28_done25", {31'd0, done}, 32'd1);
                chk("p28_cnt25", {24'd0, count_done}, 32'd3);
            end
        end
        run_ppt = 1'b0;
        cyc();
        chk("p28_idle_done", {31'd0, done}, 32'd0);
        chk("p28_idle_cnt", {24'd0, count_done}, 32'd3);
        cyc();

        // width change mid-run ignored
        run_ppt = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 1)
                chk("p29_cnt_clr", {24'd0, count_done}, 32'd0);
            chk($sformatf("p29_pulse_k%0d", k), {31'd0, pulse_out},
                {31'd0, exp_p28(k)});
            if (k == 5)
                width = 15'd3;
        end
        run_ppt = 1'b0;
        width   = 15'd1;
        repeat (2) cyc();

        // abort at T+12
        run_ppt = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 12)
                run_ppt = 1'b0;
        end
        cyc();
        chk("p32_pulse", {31'd0, pulse_out}, 32'd0);
        chk("p32_cnt", {24'd0, count_done}, 32'd1);
        chk("p32_done", {31'd0, done}, 32'd0);
        cyc();
        chk("p32_hold", {24'd0, count_done}, 32'd1);
        run_ppt = 1'b1;
        cyc();
        chk("p32_reclr", {24'd0, count_done}, 32'd0);
        chk("p32_repulse", {31'd0, pulse_out}, 32'd1);
        run_ppt = 1'b0;
        repeat (2) cyc();

        // count=0 goes straight to DONE
        count   = 8'd0;
        run_ppt = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("p30_pulse_k%0d", k), {31'd0, pulse_out}, 32'd0);
        end
        chk("p30_done", {31'd0, done}, 32'd1);
        chk("p30_cnt", {24'd0, count_done}, 32'd0);
        run_ppt = 1'b0;
        cyc();
        chk("p30_idle", {31'd0, done}, 32'd0);
        cyc();

        // width >= period: continuously high
        count   = 8'd2;
        width   = 15'd6;
        run_ppt = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            chk($sformatf("p31_pulse_k%0d", k), {31'd0, pulse_out},
                {31'd0, k <= 16});
        end
        chk("p31_done", {31'd0, done}, 32'd1);
        chk("p31_cnt", {24'd0, count_done}, 32'd2);
        run_ppt = 1'b0;
        repeat (2) cyc();

        // period=0 as 1, width=0 silent, clk_div=1 (tick every 4)
        clk_div = 5'd1;
        period  = 15'd0;
        width   = 15'd0;
        run_ppt = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            chk($sformatf("pw0_pulse_k%0d", k), {31'd0, pulse_out}, 32'd0);
            if (k == 4)
                chk("pw0_cnt4", {24'd0, count_done}, 32'd0);
            if (k == 5)
                chk("pw0_cnt5", {24'd0, count_done}, 32'd1);
            if (k == 8)
                chk("pw0_done8", {31'd0, done}, 32'd0);
        end
        chk("pw0_done9", {31'd0, done}, 32'd1);
        chk("pw0_cnt9", {24'd0, count_done}, 32'd2);
        run_ppt = 1'b0;
        repeat (2) cyc();

        // asynchronous reset mid-run, then restart
        clk_div = 5'd0;
        period  = 15'd4;
        width   = 15'd1;
        count   = 8'd3;
        run_ppt = 1'b1;
        repeat (9) cyc();
        chk("ar_pre_pulse", {31'd0, pulse_out}, 32'd1);
        chk("ar_pre_cnt", {24'd0, count_done}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_pulse", {31'd0, pulse_out}, 32'd0);
        chk("ar_cnt", {24'd0, count_done}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
`ifdef PPT_CHARGE_EN
        chk("ar_chg", {31'd0, charge_out}, 32'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        cyc();
        chk("ar_restart", {31'd0, pulse_out}, 32'd1);
        cyc();
        chk("ar_restart2", {31'd0, pulse_out}, 32'd1);
        cyc();
        chk("ar_restart3", {31'd0, pulse_out}, 32'd0);
        run_ppt = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
